// File: rtl/cache_fill_fsm.sv
// Cache block fill sequencer: on a miss it streams WORDS read requests for the
// aligned block and writes returning words into the data array, then pulses the tag write.
module cache_fill_fsm #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16,
  parameter int WORDS  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_detected,
  input  logic [AWIDTH-1:0]          miss_address,
  input  logic [DWIDTH-1:0]          memory_data,
  input  logic                       memory_data_valid,
  output logic                       fsm_busy,
  output logic                       mem_read_req,
  output logic [AWIDTH-1:0]          memory_address,
  output logic                       write_data_array,
  output logic [$clog2(WORDS)-1:0]   word_index,
  output logic [DWIDTH-1:0]          fill_data,
  output logic                       write_tag_array,
  output logic [0:0]                 fsm_state
);

  localparam int IDXW = $clog2(WORDS);
  localparam int OFFB = IDXW + 1;
  localparam int CNTW = IDXW + 1;

  localparam logic [CNTW-1:0]   CNT_FULL = CNTW'(WORDS);
  localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(WORDS - 1);
  localparam logic [AWIDTH-1:0] OFF_MASK = AWIDTH'((1 << OFFB) - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]        state;
  logic [AWIDTH-1:0] base;
  logic [CNTW-1:0]   req_cnt;
  logic [CNTW-1:0]   rcv_cnt;

  logic in_fill;
  logic req_en;
  logic wr_en;
  logic last_wr;

  // Request and receive sides are gated by rst so a mid-fill reset aborts
  // in the very cycle it is asserted: no request, no write, no tag pulse.
  always_comb begin
    in_fill = (state == FILL);
    req_en  = in_fill && !rst && (req_cnt < CNT_FULL);
    wr_en   = in_fill && !rst && memory_data_valid && (rcv_cnt < CNT_FULL);
    last_wr = wr_en && (rcv_cnt == CNT_LAST);
  end

  always_comb begin
    fsm_busy         = in_fill | ((state == IDLE) & miss_detected);
    mem_read_req     = req_en;
    memory_address   = '0;
    write_data_array = wr_en;
    word_index       = '0;
    fill_data        = '0;
    write_tag_array  = last_wr;
    fsm_state        = state;
    // base is block-aligned and the offset stays below 2*WORDS, so OR never carries.
    if (req_en) begin
      memory_address = base | AWIDTH'({req_cnt[IDXW-1:0], 1'b0});
    end
    if (wr_en) begin
      word_index = rcv_cnt[IDXW-1:0];
      fill_data  = memory_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= miss_address & ~OFF_MASK;
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (req_en) begin
            req_cnt <= req_cnt + 1'b1;
          end
          if (wr_en) begin
            rcv_cnt <= rcv_cnt + 1'b1;
          end
          if (last_wr) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a fixed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based block-fill model.
module tb_cache_fill_fsm;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (WORDS=8)
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_read_req, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_data;
  logic [2:0]  word_index;
  logic [0:0]  fsm_state;

  // Second instance (WORDS=4)
  logic        m4_miss = 1'b0;
  logic [15:0] m4_addr = '0;
  logic [15:0] m4_data = '0;
  logic        m4_valid = 1'b0;
  logic        b4, r4, w4, t4;
  logic [15:0] a4, f4;
  logic [1:0]  i4;
  logic [0:0]  s4;

  cache_fill_fsm #(.DWIDTH(16), .AWIDTH(16), .WORDS(W)) u_dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .mem_read_req(mem_read_req), .memory_address(memory_address),
    .write_data_array(write_data_array), .word_index(word_index), .fill_data(fill_data),
    .write_tag_array(write_tag_array), .fsm_state(fsm_state)
  );

  cache_fill_fsm #(.DWIDTH(16), .AWIDTH(16), .WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .miss_detected(m4_miss), .miss_address(m4_addr),
    .memory_data(m4_data), .memory_data_valid(m4_valid),
    .fsm_busy(b4), .mem_read_req(r4), .memory_address(a4),
    .write_data_array(w4), .word_index(i4), .fill_data(f4),
    .write_tag_array(t4), .fsm_state(s4)
  );

  int checks = 0;
  int errors = 0;
  int obs_wr = 0;
  int obs_tag = 0;

  // Reference model: a block fill is a list of addresses still to request
  // and a list of word slots still to receive.
  bit          m_fill = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] idx_q[$];
  logic        e_busy, e_req, e_wr, e_tag;
  logic [15:0] e_addr, e_data;
  logic [2:0]  e_idx;

  function automatic void model_expect();
    e_busy = m_fill || miss_detected;
    e_req  = !rst && m_fill && (exp_q.size() > 0);
    e_addr = e_req ? exp_q[0] : 16'h0;
    e_wr   = !rst && m_fill && memory_data_valid && (idx_q.size() > 0);
    e_idx  = e_wr ? idx_q[0][2:0] : 3'd0;
    e_data = e_wr ? memory_data : 16'h0;
    e_tag  = e_wr && (idx_q.size() == 1);
  endfunction

  function automatic void model_update();
    logic [15:0] blk;
    if (rst) begin
      m_fill = 1'b0;
      exp_q.delete();
      idx_q.delete();
    end else if (!m_fill) begin
      if (miss_detected) begin
        blk = miss_address & ~16'(2 * W - 1);
        exp_q.delete();
        idx_q.delete();
        for (int i = 0; i < W; i++) begin
          exp_q.push_back(blk + 16'(2 * i));
          idx_q.push_back(16'(i));
        end
        m_fill = 1'b1;
      end
    end else begin
      if (e_req) void'(exp_q.pop_front());
      if (e_wr) void'(idx_q.pop_front());
      if (e_tag) m_fill = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".busy"}, fsm_busy, e_busy);
    chk({tag, ".req"}, mem_read_req, e_req);
    chk({tag, ".addr"}, memory_address, e_addr);
    chk({tag, ".wr"}, write_data_array, e_wr);
    chk({tag, ".idx"}, word_index, e_idx);
    chk({tag, ".data"}, fill_data, e_data);
    chk({tag, ".tag"}, write_tag_array, e_tag);
    chk({tag, ".state"}, fsm_state, m_fill);
  endtask

  // Driver: apply inputs just after a rising edge, check mid-cycle, advance model at the edge.
  task automatic step(input string tag, input logic r, input logic m, input logic [15:0] a,
                      input logic v, input logic [15:0] d);
    rst = r; miss_detected = m; miss_address = a; memory_data_valid = v; memory_data = d;
    @(negedge clk);
    model_expect();
    check_model(tag);
    if (write_data_array) obs_wr++;
    if (write_tag_array) obs_tag++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 16'h0, 1'b1, 16'($urandom));
  endtask

  typedef struct {
    logic        m;
    logic [15:0] a;
    logic        v;
    logic [15:0] d;
    logic        busy;
    logic        req;
    logic [15:0] addr;
    logic        wr;
    logic [2:0]  idx;
    logic        tag;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Miss at 0x1234, memory latency 4: requests cycles 1..8, data cycles 5..12.
    for (int k = 0; k < 14; k++) begin
      tbl[k] = '{m: 1'b0, a: 16'h0, v: 1'b0, d: 16'h0, busy: 1'b0, req: 1'b0,
                 addr: 16'h0, wr: 1'b0, idx: 3'd0, tag: 1'b0};
      if (k == 0) begin tbl[k].m = 1'b1; tbl[k].a = 16'h1234; end
      if (k <= 12) tbl[k].busy = 1'b1;
      if (k >= 1 && k <= 8) begin tbl[k].req = 1'b1; tbl[k].addr = 16'h1230 + 16'(2 * (k - 1)); end
      if (k >= 5 && k <= 12) begin
        tbl[k].v = 1'b1; tbl[k].d = 16'hA000 + 16'(k); tbl[k].wr = 1'b1; tbl[k].idx = 3'(k - 5);
      end
      if (k == 12) tbl[k].tag = 1'b1;
    end

    @(posedge clk); #1;
    step("reset0", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step("reset_valid", 1'b1, 1'b0, 16'h0, 1'b1, 16'h5A5A);
    step("idle_valid", 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);

    for (int k = 0; k < 14; k++) begin
      rst = 1'b0; miss_detected = tbl[k].m; miss_address = tbl[k].a;
      memory_data_valid = tbl[k].v; memory_data = tbl[k].d;
      @(negedge clk);
      chk($sformatf("vec%0d.busy", k), fsm_busy, tbl[k].busy);
      chk($sformatf("vec%0d.req", k), mem_read_req, tbl[k].req);
      chk($sformatf("vec%0d.addr", k), memory_address, tbl[k].addr);
      chk($sformatf("vec%0d.wr", k), write_data_array, tbl[k].wr);
      chk($sformatf("vec%0d.idx", k), word_index, tbl[k].idx);
      chk($sformatf("vec%0d.data", k), fill_data, tbl[k].wr ? tbl[k].d : 16'h0);
      chk($sformatf("vec%0d.tag", k), write_tag_array, tbl[k].tag);
      model_expect();
      @(posedge clk);
      model_update();
      #1;
    end

    // WORDS=4, miss at 0xFFFF: block 0xFFF8, data returned alongside each request.
    m4_miss = 1'b1; m4_addr = 16'hFFFF;
    @(negedge clk);
    chk("w4.miss_busy", b4, 1'b1);
    chk("w4.miss_req", r4, 1'b0);
    @(posedge clk); #1;
    m4_miss = 1'b0; m4_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m4_data = 16'h0010 + 16'(i);
      @(negedge clk);
      chk($sformatf("w4.addr%0d", i), {r4, a4}, {1'b1, 16'hFFF8 + 16'(2 * i)});
      chk($sformatf("w4.wr%0d", i), {w4, i4, f4}, {1'b1, 2'(i), 16'h0010 + 16'(i)});
      chk($sformatf("w4.tag%0d", i), t4, (i == 3));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("w4.done_busy", b4, 1'b0);
    chk("w4.done_req", r4, 1'b0);
    chk("w4.done_wr", w4, 1'b0);
    @(posedge clk); #1;
    m4_valid = 1'b0;

    // Gapped valid: one valid every third cycle.
    obs_wr = 0; obs_tag = 0;
    step("gap_miss", 1'b0, 1'b1, 16'h2222, 1'b0, 16'h0);
    for (int i = 0; i < 24; i++) step("gap", 1'b0, 1'b0, 16'h0, (i % 3 == 0), 16'($urandom));
    step("gap_end", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("gap.writes", obs_wr, 8);
    chk("gap.tags", obs_tag, 1);

    // Reset after three received words aborts the fill; a new miss restarts cleanly.
    obs_wr = 0; obs_tag = 0;
    step("abort_miss", 1'b0, 1'b1, 16'h1000, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step("abort_rx", 1'b0, 1'b0, 16'h0, 1'b1, 16'hC000 + 16'(i));
    step("abort_rst", 1'b1, 1'b0, 16'h0, 1'b1, 16'hDEAD);
    step("abort_after", 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF);
    chk("abort.busy_low", fsm_busy, 1'b0);
    chk("abort.tags", obs_tag, 0);
    step("restart_miss", 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0);
    rst = 1'b0; miss_detected = 1'b0; memory_data_valid = 1'b1; memory_data = 16'h7777;
    @(negedge clk);
    chk("restart.addr", {mem_read_req, memory_address}, {1'b1, 16'h0040});
    chk("restart.idx", {write_data_array, word_index}, {1'b1, 3'd0});
    model_expect();
    @(posedge clk); model_update(); #1;
    drain("restart_drain", 10);

    // Miss held high with a different address during the fill.
    step("hold_miss", 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) step("hold", 1'b0, 1'b1, 16'hBEEF, (i >= 2), 16'($urandom));
    drain("hold_drain", 12);

    // Ten valid pulses for an eight-word block.
    obs_wr = 0; obs_tag = 0;
    step("extra_miss", 1'b0, 1'b1, 16'h5550, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) step("extra", 1'b0, 1'b0, 16'h0, 1'b1, 16'($urandom));
    chk("extra.writes", obs_wr, 8);
    chk("extra.tags", obs_tag, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
    end
    drain("final_drain", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL take parameter DWIDTH, default 16, data word width in bits.
REQ-002 SHALL take parameter AWIDTH, default 16, byte-address width in bits.
REQ-003 SHALL take parameter WORDS, default 8, words per cache block; legal values are powers of two from 2 to 16.
REQ-004 SHALL derive localparam IDXW = log2(WORDS), the word-index width.
REQ-005 SHALL derive localparam OFFB = IDXW+1, the byte-offset bits in a block address.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL provide clk  input  1  system clock, with all state updated on rising edge.
REQ-008 SHALL provide rst  input  1  synchronous active-high reset.
REQ-009 SHALL provide miss_detected  input  1  cache miss request from the pipeline.
REQ-010 SHALL provide miss_address  input  AWIDTH  byte address of the missing word.
REQ-011 SHALL provide memory_data  input  DWIDTH  read data returned by memory.
REQ-012 SHALL provide memory_data_valid  input  1  memory_data valid this cycle.
REQ-013 SHALL provide fsm_busy  output  1  fill in progress; the pipeline stalls.
REQ-014 SHALL provide mem_read_req  output  1  memory read request this cycle.
REQ-015 SHALL provide memory_address  output  AWIDTH  request address, meaningful only while mem_read_req=1.
REQ-016 SHALL provide write_data_array  output  1  write fill_data into the block at word_index.
REQ-017 SHALL provide word_index  output  IDXW  destination word within the block.
REQ-018 SHALL provide fill_data  output  DWIDTH  data to write to the block.
REQ-019 SHALL provide write_tag_array  output  1  one-cycle pulse that updates the tag/valid bit.

Function
REQ-020 SHALL implement two states: IDLE and FILL.
REQ-021 SHALL, in IDLE with miss_detected=1, latch base = miss_address with the low OFFB bits cleared.
REQ-022 SHALL, on that same IDLE+miss_detected event, clear both counters and enter FILL on the next edge.
REQ-023 SHALL drive fsm_busy combinationally as (state==FILL) | (state==IDLE & miss_detected), so the stall begins in the miss cycle.
REQ-024 SHALL maintain a request counter req_cnt (IDXW+1 bits) in FILL.
REQ-025 SHALL assert mem_read_req while req_cnt<WORDS, with memory_address = base + 2*req_cnt.
REQ-026 SHALL increment req_cnt once per such cycle, so WORDS back-to-back requests issue starting the first FILL cycle.
REQ-027 SHALL maintain a receive counter rcv_cnt (IDXW+1 bits), independent of req_cnt.
REQ-028 SHALL, on each FILL cycle with memory_data_valid=1 and rcv_cnt<WORDS, drive write_data_array=1, word_index=rcv_cnt[IDXW-1:0], fill_data=memory_data, and increment rcv_cnt.
REQ-029 SHALL make write_data_array, word_index and fill_data combinational from the current-cycle inputs, with zero added latency.
REQ-030 SHALL assert write_tag_array in the same cycle as the data write with rcv_cnt==WORDS-1.
REQ-031 SHALL return to IDLE on the next edge after the REQ-030 cycle, and SHALL deassert fsm_busy then unless a new miss is present.
REQ-032 SHALL accept request issue and data receipt in the same cycle; the counters advance independently.
REQ-033 SHALL ignore memory_data_valid while in IDLE, and SHALL ignore it in FILL once rcv_cnt==WORDS, with no write.
REQ-034 SHALL ignore miss_detected while in FILL; the latched base is unchanged.
REQ-035 SHALL keep all addresses within the block; base is block-aligned, so there is no carry into the tag bits.
REQ-036 SHALL, in IDLE, hold mem_read_req=0, write_data_array=0 and write_tag_array=0.

Reset
REQ-037 SHALL, on rst=1 at a clock edge, set state=IDLE, req_cnt=0, rcv_cnt=0 and base=0.
REQ-038 SHALL make the reset values of all outputs 0 while rst is held and the IDLE state has no miss present.
REQ-039 SHALL treat reset mid-FILL as an abort: no further requests or array writes, and no write_tag_array pulse.

Verification
REQ-040 SHALL cover: WORDS=8, miss_address=0x1234, memory latency 4 -> base 0x1230; requests 0x1230,0x1232,...,0x123E on 8 consecutive cycles; writes at word_index 0..7; write_tag_array pulse with the 8th write; busy for 1+4+8 cycles.
REQ-041 SHALL cover: gapped memory_data_valid (1,0,0,1,...) -> word_index advances only on valid cycles; tag pulse only on the 8th valid.
REQ-042 SHALL cover: rst=1 after 3 valid words -> next cycle busy=0; no tag pulse; a new miss to 0x0040 restarts at word_index 0, address 0x0040.
REQ-043 SHALL cover: miss_detected held high during FILL with miss_address=0xBEEF -> requests stay on the original base.
REQ-044 SHALL cover: 10 valid pulses for WORDS=8 -> exactly 8 data writes and 1 tag write; the extra pulses are ignored.
REQ-045 SHALL cover: WORDS=4, miss_address=0xFFFF -> base 0xFFF8; addresses 0xFFF8..0xFFFE with no wrap beyond the block.
